// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the core (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        dstall;

  modport master (
    output MemWriteM, MemtoRegM, ALUOutM, WriteDataM,
    input  ReadDataM, dstall
  );

  modport slave (
    input  MemWriteM, MemtoRegM, ALUOutM, WriteDataM,
    output ReadDataM, dstall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-side responder: optional direct-mapped write-through cache (`DMEM_CACHE_EN) in front of a
// fixed-latency word-addressed backing store; dstall freezes the pipeline while an access is in flight.
module dmem_responder #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int unsigned MW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   result_q;
  logic          store_q;
  logic [31:0]   mem [MEM_WORDS];

  logic [29:0]   word;
  logic          is_store, is_load, hit, start, commit;
  logic [31:0]   hit_data;
  logic [MW-1:0] maddr;
  logic          unused_bits;

  assign word        = bus.ALUOutM[31:2];
  assign is_store    = bus.MemWriteM;
  assign is_load     = bus.MemtoRegM & ~bus.MemWriteM;
  assign commit      = (state_q == BUSY) && (cnt_q == '0);
  assign maddr       = addr_q[MW-1:0];
  assign unused_bits = ^{bus.ALUOutM[1:0], addr_q};

`ifdef DMEM_CACHE_EN
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - IW;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      line_q [LINES];
  logic [IW-1:0]    idx, cidx;
  logic [TW-1:0]    tag, ctag;
  logic             chit;

  assign idx      = word[IW-1:0];
  assign tag      = word[29:IW];
  assign cidx     = addr_q[IW-1:0];
  assign ctag     = addr_q[29:IW];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign chit     = valid_q[cidx] && (tag_q[cidx] == ctag);
  assign hit_data = line_q[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (commit && !store_q) begin
      valid_q[cidx] <= 1'b1;
    end
  end

  // Stores update a resident line only; misses never allocate.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (!store_q) begin
        tag_q[cidx]  <= ctag;
        line_q[cidx] <= mem[maddr];
      end else if (chit) begin
        line_q[cidx] <= wdata_q;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // commit is qualified by state_q, which reset forces to IDLE, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (commit && store_q) begin
      mem[maddr] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q   <= CW'(LATENCY - 1);
        addr_q  <= word;
        wdata_q <= bus.WriteDataM;
        store_q <= is_store;
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (commit && !store_q) begin
        result_q <= mem[maddr];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    bus.dstall    = 1'b0;
    bus.ReadDataM = '0;
    unique case (state_q)
      IDLE: begin
        if (is_store || (is_load && !hit)) begin
          start      = 1'b1;
          bus.dstall = 1'b1;
          state_d    = BUSY;
        end else if (is_load) begin
          bus.ReadDataM = hit_data;
        end
      end
      BUSY: begin
        bus.dstall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (!store_q) bus.ReadDataM = result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word/line-level reference model.
module tb_dmem_responder;
  localparam int unsigned LINES     = 16;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned NWORDS    = 48;
`ifdef DMEM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  dmem_responder_if bus ();

  dmem_responder #(
    .LINES     (LINES),
    .LATENCY   (LATENCY),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: backing store contents and which word each cache line holds.
  logic [31:0]  mem_m  [MEM_WORDS];
  bit           lv_m   [LINES];
  int unsigned  lw_m   [LINES];
  logic [31:0]  ld_m   [LINES];

  task automatic idle_inputs();
    bus.MemWriteM  = 1'b0;
    bus.MemtoRegM  = 1'b0;
    bus.ALUOutM    = '0;
    bus.WriteDataM = '0;
  endtask

  task automatic clear_lines();
    for (int i = 0; i < int'(LINES); i++) lv_m[i] = 1'b0;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the edge that ends the request.
  task automatic xact(input bit st, input bit ld, input logic [31:0] addr, input logic [31:0] wd,
                      input bit scr, input string nm, output logic [31:0] got);
    int unsigned w, mi, li;
    int          exp_stall, n;
    logic [31:0] exp_rd;
    bit          hit;
    w  = int'(addr[31:2]);
    mi = w % MEM_WORDS;
    li = w % LINES;
    hit = CACHE_EN && lv_m[li] && (lw_m[li] == w);
    if (st) begin
      exp_stall = LATENCY + 1;
      exp_rd    = '0;
      mem_m[mi] = wd;
      if (hit) ld_m[li] = wd;
    end else if (ld) begin
      if (hit) begin
        exp_stall = 0;
        exp_rd    = ld_m[li];
      end else begin
        exp_stall = LATENCY + 1;
        exp_rd    = mem_m[mi];
        if (CACHE_EN) begin
          lv_m[li] = 1'b1;
          lw_m[li] = w;
          ld_m[li] = mem_m[mi];
        end
      end
    end else begin
      exp_stall = 0;
      exp_rd    = '0;
    end

    bus.MemWriteM  = st;
    bus.MemtoRegM  = ld;
    bus.ALUOutM    = addr;
    bus.WriteDataM = wd;
    n = 0;
    @(negedge clk);
    while (bus.dstall === 1'b1 && n < int'(LATENCY) + 8) begin
      n++;
      @(posedge clk);
      #1;
      if (scr) begin
        bus.MemWriteM  = 1'($urandom);
        bus.MemtoRegM  = 1'($urandom);
        bus.ALUOutM    = $urandom;
        bus.WriteDataM = $urandom;
      end
      @(negedge clk);
    end
    vectors++;
    if (n !== exp_stall)
      $display("FAIL %s stall_cycles addr=%h got=%0d exp=%0d", nm, addr, n, exp_stall);
    if (n !== exp_stall) miscompares++;
    vectors++;
    if (bus.ReadDataM !== exp_rd) begin
      $display("FAIL %s ReadDataM addr=%h got=%h exp=%h", nm, addr, bus.ReadDataM, exp_rd);
      miscompares++;
    end
    got = bus.ReadDataM;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    clear_lines();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.dstall !== 1'b0) begin
      $display("FAIL reset_in dstall got=%b exp=0", bus.dstall);
      miscompares++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.dstall !== 1'b0) begin
      $display("FAIL reset_idle dstall got=%b exp=0", bus.dstall);
      miscompares++;
    end
    vectors++;
    if (bus.ReadDataM !== 32'h0) begin
      $display("FAIL reset_idle ReadDataM got=%h exp=0", bus.ReadDataM);
      miscompares++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_init_store();
    logic [31:0] g;
    for (int unsigned w = 0; w < NWORDS; w++) xact(1'b1, 1'b0, w << 2, '0, 1'b0, "init", g);
  endtask

  task automatic test_store_load();
    logic [31:0] g;
    xact(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, "store40", g);
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "load40_miss", g);
    vectors++;
    if (g !== 32'hDEADBEEF) begin
      $display("FAIL load40_value got=%h exp=deadbeef", g);
      miscompares++;
    end
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "load40_repeat", g);
    vectors++;
    if (g !== 32'hDEADBEEF) begin
      $display("FAIL load40_repeat_value got=%h exp=deadbeef", g);
      miscompares++;
    end
  endtask

  task automatic test_conflict();
    logic [31:0] g;
    xact(1'b0, 1'b1, 32'h80, '0, 1'b0, "load80_conflict", g);
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "reload40", g);
    vectors++;
    if (g !== 32'hDEADBEEF) begin
      $display("FAIL reload40_value got=%h exp=deadbeef", g);
      miscompares++;
    end
    xact(1'b1, 1'b0, 32'h40, 32'h12345678, 1'b0, "store40_resident", g);
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "load40_updated", g);
    vectors++;
    if (g !== 32'h12345678) begin
      $display("FAIL load40_updated_value got=%h exp=12345678", g);
      miscompares++;
    end
  endtask

  task automatic test_both_high();
    logic [31:0] g;
    xact(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, "both_high44", g);
    xact(1'b0, 1'b1, 32'h44, '0, 1'b0, "load44_after_both", g);
    vectors++;
    if (g !== 32'hCAFEF00D) begin
      $display("FAIL load44_value got=%h exp=cafef00d", g);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] g;
    bus.MemWriteM  = 1'b1;
    bus.ALUOutM    = 32'h48;
    bus.WriteDataM = 32'hA5A5A5A5;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    idle_inputs();
    clear_lines();
    #1;
    vectors++;
    if (bus.dstall !== 1'b0) begin
      $display("FAIL abort_dstall got=%b exp=0", bus.dstall);
      miscompares++;
    end
    vectors++;
    if (bus.ReadDataM !== 32'h0) begin
      $display("FAIL abort_ReadDataM got=%h exp=0", bus.ReadDataM);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xact(1'b0, 1'b1, 32'h48, '0, 1'b0, "load48_after_abort", g);
    vectors++;
    if (g !== 32'h0) begin
      $display("FAIL load48_value got=%h exp=0", g);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    int unsigned k;
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, NWORDS - 1) << 2) | 32'($urandom_range(0, 3));
      case (k)
        0, 1, 2, 3: xact(1'b0, 1'b1, a, $urandom, 1'($urandom), "rnd_load", g);
        4, 5, 6:    xact(1'b1, 1'b0, a, $urandom, 1'($urandom), "rnd_store", g);
        7:          xact(1'b1, 1'b1, a, $urandom, 1'($urandom), "rnd_both", g);
        default:    xact(1'b0, 1'b0, a, $urandom, 1'b0, "rnd_idle", g);
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "b2b_load40_a", g);
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "b2b_load40_b", g);
    xact(1'b1, 1'b0, 32'h40, 32'h0BADF00D, 1'b0, "b2b_store40", g);
    xact(1'b0, 1'b1, 32'h40, '0, 1'b0, "b2b_load40_c", g);
    vectors++;
    if (g !== 32'h0BADF00D) begin
      $display("FAIL b2b_load40_value got=%h exp=0badf00d", g);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    test_reset();
    test_init_store();
    test_store_load();
    test_conflict();
    test_both_high();
    test_reset_mid_store();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined core. It services the Memory-stage request (MemWriteM, MemtoRegM, ALUOutM, WriteDataM), returns ReadDataM, and drives dstall so the hazard unit freezes the pipeline while an access is in flight. It contains:
- a direct-mapped, write-through, no-write-allocate cache of one-word lines;
- a word-addressed backing store with fixed multi-cycle latency.

## Interface
Parameters:
- LINES, 16: cache lines, one 32-bit word each; power of two, ≥2.
- LATENCY, 4: backing-store access cycles; ≥1.
- MEM_WORDS, 1024: backing-store depth in words; power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  load request.
- ALUOutM  in  32  byte address; bits [1:0] ignored.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data.
- dstall  out  1  high while the current request is incomplete.

## Operation
- Address decode:
  - word = ALUOutM[31:2];
  - index = word mod LINES;
  - tag = remaining upper word bits;
  - backing-store address = word mod MEM_WORDS (wraps silently).
- Per line: valid bit, tag, data. All valid bits clear on reset. Backing store is not reset.
- Request decode: MemWriteM=1 is a store, regardless of MemtoRegM. Store has priority if both are high. MemtoRegM=1 alone is a load. Neither high means idle.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Load hit (valid and tag match): ReadDataM = line data combinationally, dstall=0, stay IDLE.
  - Load miss: dstall=1, counter←LATENCY-1, capture address, go BUSY(load).
  - Store: dstall=1, counter←LATENCY-1, capture address and data, go BUSY(store).
  - Idle request: dstall=0, ReadDataM=0.
- BUSY:
  - dstall=1 every cycle.
  - counter≠0: decrement.
  - counter=0, load: read the backing store into the result register, fill the line (valid=1, tag, data), go DONE.
  - counter=0, store: write the backing store. If the line hits, update its data; on a miss, do not allocate. Go DONE.
- DONE:
  - dstall=0; the pipeline advances at the end of this cycle.
  - ReadDataM = result register for a load, 0 for a store.
  - Always go IDLE next. The request still presented during DONE is the completed one and is not re-issued.
- The CPU must hold M-stage inputs stable while dstall=1. The block uses the captured copies, so input changes during BUSY have no effect.
- Reset asserted mid-operation: return to IDLE immediately and clear all valid bits. An in-flight store that has not reached counter=0 is not committed to the backing store.

## Timing
- Load hit: 1 cycle, dstall never high.
- Load miss and store:
  - dstall high for LATENCY+1 consecutive cycles (the IDLE detect cycle plus LATENCY BUSY cycles);
  - then 1 DONE cycle with dstall=0;
  - total occupancy LATENCY+2 cycles.
- Back-to-back requests: the next request is sampled in IDLE, the cycle after DONE.
- A load to the same word as the previous store sees the stored value. It hits if the line was resident; otherwise it misses and reads the committed backing store.
- Reset values: state=IDLE, dstall=0, ReadDataM=0 (no request), counter=0, result register=0, all valid=0.

## Configuration
- DMEM_CACHE_EN defined: cache present as described above.
- DMEM_CACHE_EN undefined:
  - no tag/valid/data arrays;
  - every load takes the miss path (LATENCY+2 cycles);
  - stores are unchanged apart from the absent line update;
  - port list is identical.

## Test plan
- After reset with no requests: dstall=0, ReadDataM=0.
- Store 0xDEADBEEF to 0x40, LATENCY=4: dstall high 5 cycles, then DONE. Load 0x40: miss, dstall high 5 cycles, ReadDataM=0xDEADBEEF in DONE. Repeat load: hit, dstall=0, same data in the same cycle.
- Conflict: load 0x40, then load 0x80 with LINES=16 (same index 0). Both miss. A reload of 0x40 misses again and returns 0xDEADBEEF.
- Store 0x12345678 to a resident 0x40: line updated. A following load hits with 0x12345678.
- Store with MemWriteM=MemtoRegM=1 to 0x44: treated as a store, ReadDataM=0 in DONE.
- Reset low during BUSY of a store of 0xA5A5A5A5 to 0x48 (prior value 0): immediate IDLE, dstall=0. A later load of 0x48 misses and returns 0.
- Build without DMEM_CACHE_EN: two successive loads of 0x40 both stall 5 cycles.
